edt_sol_sequencer: RTL and testbench

EDT_SOL_SEQUENCER -- requirements
Module: edt_sol_sequencer

---
 rtl/edt_sol_sequencer.sv | 168 ++++++++++++++++
 tb/tb_edt_sol_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/edt_sol_sequencer.sv
// rtl/edt_sol_sequencer.sv - EDT reset/jam and SOL observation-window sequencer.
// Optional SOL_SEQ_STICKY_FAIL_EN keeps fail set across starts until ijtag_reset.
module edt_sol_sequencer #(
  parameter int CNT_W = 15,
  parameter int RUN_W = 16
) (
  input  logic             ijtag_tck,
  input  logic             ijtag_reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             cfg_mask,
  input  logic             cfg_mode,
  input  logic [3:0]       cfg_reset_cycles,
  input  logic [RUN_W-1:0] cfg_run_cycles,
  input  logic             sol_event,
  output logic             edt_reset_b,
  output logic             edt_jam,
  output logic             sol_init,
  output logic             sol_mode,
  output logic             sol_mask,
  output logic [CNT_W-1:0] sol_thresh,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [CNT_W-1:0] event_count
);

  typedef enum logic [2:0] {IDLE, HOLD, INIT, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [RUN_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         sh_rc_q, sh_rc_d;
  logic [RUN_W-1:0]   sh_run_q, sh_run_d;
  logic [CNT_W-1:0]   sh_thresh_q, sh_thresh_d;
  logic               sh_mode_q, sh_mode_d;
  logic               sh_mask_q, sh_mask_d;
  logic [CNT_W-1:0]   event_count_q, event_count_d;
  logic               fail_q, fail_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               edt_reset_b_q, edt_reset_b_d;
  logic               edt_jam_q, edt_jam_d;
  logic               sol_init_q, sol_init_d;
  logic               inc;
  logic               hit;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sh_rc_d       = sh_rc_q;
    sh_run_d      = sh_run_q;
    sh_thresh_d   = sh_thresh_q;
    sh_mode_d     = sh_mode_q;
    sh_mask_d     = sh_mask_q;
    event_count_d = event_count_q;
    fail_d        = fail_q;
    done_d        = done_q;
    inc           = 1'b0;
    hit           = 1'b0;

    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d       = HOLD;
            cnt_d         = '0;
            sh_rc_d       = cfg_reset_cycles;
            sh_run_d      = cfg_run_cycles;
            sh_thresh_d   = cfg_thresh;
            sh_mode_d     = cfg_mode;
            sh_mask_d     = cfg_mask;
            event_count_d = '0;
            done_d        = 1'b0;
`ifndef SOL_SEQ_STICKY_FAIL_EN
            fail_d        = 1'b0;
`endif
          end
        end
        HOLD: begin
          if (cnt_q == RUN_W'(sh_rc_q)) begin
            state_d = INIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        INIT: begin
          state_d = RUN;
          cnt_d   = '0;
        end
        RUN: begin
          // Saturate: stop incrementing once the counter is all-ones.
          inc           = sol_event && !sh_mask_q && (event_count_q != '1);
          event_count_d = event_count_q + {{(CNT_W-1){1'b0}}, inc};
          hit           = (sh_thresh_q != '0) && (event_count_d >= sh_thresh_q);
          if ((sh_mode_q && hit) || (cnt_q == sh_run_q)) begin
            state_d = DONE;
            done_d  = 1'b1;
`ifdef SOL_SEQ_STICKY_FAIL_EN
            fail_d  = fail_q | hit;
`else
            fail_d  = hit;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    edt_reset_b_d = (state_d != HOLD);
    edt_jam_d     = (state_d == HOLD) || (state_d == INIT);
    sol_init_d    = (state_d == INIT);
    busy_d        = (state_d == HOLD) || (state_d == INIT) || (state_d == RUN);
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sh_rc_q       <= '0;
      sh_run_q      <= '0;
      sh_thresh_q   <= '0;
      sh_mode_q     <= 1'b0;
      sh_mask_q     <= 1'b0;
      event_count_q <= '0;
      fail_q        <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      edt_reset_b_q <= 1'b1;
      edt_jam_q     <= 1'b0;
      sol_init_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_rc_q       <= sh_rc_d;
      sh_run_q      <= sh_run_d;
      sh_thresh_q   <= sh_thresh_d;
      sh_mode_q     <= sh_mode_d;
      sh_mask_q     <= sh_mask_d;
      event_count_q <= event_count_d;
      fail_q        <= fail_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      edt_reset_b_q <= edt_reset_b_d;
      edt_jam_q     <= edt_jam_d;
      sol_init_q    <= sol_init_d;
    end
  end

  assign edt_reset_b = edt_reset_b_q;
  assign edt_jam     = edt_jam_q;
  assign sol_init    = sol_init_q;
  assign sol_mode    = sh_mode_q;
  assign sol_mask    = sh_mask_q;
  assign sol_thresh  = sh_thresh_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign event_count = event_count_q;

endmodule

// File: tb/tb_edt_sol_sequencer.sv
// tb/tb_edt_sol_sequencer.sv - scoreboard bench for edt_sol_sequencer.
module tb_edt_sol_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [14:0] cfg_thresh = '0;
  logic        cfg_mask = 1'b0, cfg_mode = 1'b0;
  logic [3:0]  cfg_reset_cycles = '0;
  logic [15:0] cfg_run_cycles = '0;
  logic        sol_event = 1'b0;
  logic        edt_reset_b, edt_jam, sol_init, sol_mode, sol_mask;
  logic [14:0] sol_thresh, event_count;
  logic        busy, done, fail;

  edt_sol_sequencer dut (
    .ijtag_tck(clk), .ijtag_reset(rst), .start(start), .abort(abort),
    .cfg_thresh(cfg_thresh), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
    .cfg_reset_cycles(cfg_reset_cycles), .cfg_run_cycles(cfg_run_cycles),
    .sol_event(sol_event), .edt_reset_b(edt_reset_b), .edt_jam(edt_jam),
    .sol_init(sol_init), .sol_mode(sol_mode), .sol_mask(sol_mask),
    .sol_thresh(sol_thresh), .busy(busy), .done(done), .fail(fail),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hold;
    int init;
    int run;
    int count;
    int fail;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_fail = 0;
`ifdef SOL_SEQ_STICKY_FAIL_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Expected fail follows the sticky/non-sticky rule across runs.
  task automatic push(input int h, input int i, input int r, input int c, input int f);
    exp_t e;
    exp_fail = STICKY ? (exp_fail | f) : f;
    e.hold = h; e.init = i; e.run = r; e.count = c; e.fail = exp_fail;
    exp_q.push_back(e);
  endtask

  // Monitor: measures phase lengths and scores every completed sequence.
  int   hold_n = 0, init_n = 0, run_n = 0;
  logic busy_p = 1'b0, done_p = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && !busy_p) begin
        hold_n = 0; init_n = 0; run_n = 0;
      end
      if (!edt_reset_b) hold_n++;
      if (sol_init) init_n++;
      if (busy && !edt_jam) run_n++;
      if (done && !done_p) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("hold_len", hold_n, e.hold);
          check("init_len", init_n, e.init);
          check("run_len", run_n, e.run);
          check("event_count", int'(event_count), e.count);
          check("fail", int'(fail), e.fail);
        end
      end
      busy_p = busy;
      done_p = done;
    end
  end

  task automatic do_start(input int rc, input int run, input int thr,
                          input bit mode, input bit mask);
    cfg_reset_cycles = 4'(rc);
    cfg_run_cycles   = 16'(run);
    cfg_thresh       = 15'(thr);
    cfg_mode         = mode;
    cfg_mask         = mask;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!(busy && !edt_jam) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("wait_run_timeout", 1, 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("wait_done_timeout", 1, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_edt_reset_b", int'(edt_reset_b), 1);
    check("rst_jam", int'(edt_jam), 0);
    check("rst_busy_done", int'({busy, done, sol_init}), 0);
    check("rst_fail_count", int'({fail, event_count}), 0);
    check("rst_shadows", int'({sol_mode, sol_mask, sol_thresh}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Plain run, no threshold, no events.
    push(4, 1, 10, 0, 0);
    do_start(3, 9, 0, 1'b0, 1'b0);
    wait_done(200);

    // Threshold 5, full window; events held high before RUN must be ignored.
    sol_event = 1'b1;
    push(4, 1, 20, 7, 1);
    do_start(3, 19, 5, 1'b0, 1'b0);
    wait_run();
    for (int i = 0; i < 20; i++) begin
      sol_event = (i < 7);
      @(negedge clk);
    end
    sol_event = 1'b0;
    wait_done(200);

    // Early stop on threshold.
    sol_event = 1'b1;
    push(2, 1, 5, 5, 1);
    do_start(1, 19, 5, 1'b1, 1'b0);
    check("sol_thresh_shadow", int'(sol_thresh), 5);
    check("sol_mode_shadow", int'(sol_mode), 1);
    wait_done(200);

    // Masked events, minimum hold.
    push(1, 1, 10, 0, 0);
    do_start(0, 9, 5, 1'b1, 1'b1);
    check("sol_mask_shadow", int'(sol_mask), 1);
    wait_done(200);
    sol_event = 1'b0;

    // Abort in second RUN cycle; restart during HOLD is ignored.
    do_start(2, 9, 0, 1'b0, 1'b0);
    if (!STICKY) exp_fail = 0;
    cfg_run_cycles = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_run();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_jam", int'(edt_jam), 0);
    check("abort_done", int'(done), 0);
    check("abort_reset_b", int'(edt_reset_b), 1);
    check("abort_fail_kept", int'(fail), exp_fail);

    // Config changes and start while busy have no effect.
    push(4, 1, 5, 0, 0);
    do_start(3, 4, 0, 1'b0, 1'b0);
    cfg_thresh = 15'd9;
    cfg_run_cycles = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_cfg_ignored", int'(sol_thresh), 0);
    wait_done(200);

    // Fail run followed by a clean run.
    push(1, 1, 5, 1, 1);
    do_start(0, 4, 1, 1'b0, 1'b0);
    wait_run();
    sol_event = 1'b1;
    @(negedge clk);
    sol_event = 1'b0;
    wait_done(200);
    push(1, 1, 3, 0, 0);
    do_start(0, 2, 0, 1'b0, 1'b0);
    wait_done(200);

    // Saturation over the maximum window, maximum hold.
    sol_event = 1'b1;
    push(16, 1, 65536, 32767, 0);
    do_start(15, 65535, 0, 1'b0, 1'b0);
    wait_done(70000);
    sol_event = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
